// File: rtl/dcache_controller.sv
// dcache_controller: 16-line x 32-byte direct-mapped, write-back, write-allocate
// data cache controller for a MEM-stage CPU port with a single block-wide memory port.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   cpu_req_i/cpu_write_i   access valid / store(1) or load(0)
//   cpu_addr_i              byte address: tag [31:9], index [8:5], word [4:2]
//   cpu_data_i/cpu_data_o   store data / load data (zero-latency on read hit)
//   cpu_stall_o             pipeline freeze; CPU holds cpu_* stable while high
//   mem_enable_o            memory request, held until mem_ack_i
//   mem_write_o             1 = block write-back, 0 = block fetch
//   mem_addr_o/mem_data_o   block address / write-back block
//   mem_data_i/mem_ack_i    fetched block / one-cycle completion pulse
//
// Optional build macro DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o access counters.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o,
`endif
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {StIdle, StWriteback, StReadmiss, StRefilled} state_e;

  state_e state_q, state_d;

  logic [255:0] data_q [16];
  logic [22:0]  tag_q  [16];
  logic [15:0]  valid_q, valid_d;
  logic [15:0]  dirty_q, dirty_d;

  logic [3:0]   idx;
  logic [2:0]   word;
  logic [22:0]  req_tag;
  logic [255:0] cur_line;
  logic         hit;

  logic         line_we;
  logic [255:0] line_wdata;
  logic         tag_we;

  logic         unused_addr;

  assign idx         = cpu_addr_i[8:5];
  assign word        = cpu_addr_i[4:2];
  assign req_tag     = cpu_addr_i[31:9];
  assign unused_addr = ^cpu_addr_i[1:0];
  assign cur_line    = data_q[idx];

  assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign cpu_stall_o = (state_q != StIdle) | (cpu_req_i & ~hit);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we      = 1'b0;
    line_wdata   = cur_line;
    tag_we       = 1'b0;
    cpu_data_o   = 32'h0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 256'h0;

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          if (cpu_write_i) begin
            line_we                      = 1'b1;
            line_wdata[{word, 5'b0} +: 32] = cpu_data_i;
            dirty_d[idx]                 = 1'b1;
          end else begin
            cpu_data_o = cur_line[{word, 5'b0} +: 32];
          end
        end else if (cpu_req_i) begin
          state_d = (valid_q[idx] & dirty_q[idx]) ? StWriteback : StReadmiss;
        end
      end

      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = cur_line;
        if (mem_ack_i) state_d = StReadmiss;
      end

      StReadmiss: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_addr_i[31:5], 5'b0};
        if (mem_ack_i) begin
          line_we      = 1'b1;
          line_wdata   = mem_data_i;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = StRefilled;
        end
      end

      // One bubble so the access replays in IDLE as an ordinary hit.
      StRefilled: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      valid_q <= 16'h0;
      dirty_q <= 16'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Arrays are not reset; while rst_i is low the FSM sits in IDLE with no valid
  // lines, so neither write enable can fire.
  always_ff @(posedge clk_i) begin
    if (line_we) data_q[idx] <= line_wdata;
    if (tag_we)  tag_q[idx]  <= req_tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        refill_done_q, refill_done_d;

  always_comb begin
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    refill_done_d = (state_q == StRefilled);
    // The replay hit right after a refill belongs to the miss already counted.
    if ((state_q == StIdle) && cpu_req_i && !refill_done_q) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q     <= 32'h0;
      miss_cnt_q    <= 32'h0;
      refill_done_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      refill_done_q <= refill_done_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed self-checking bench for dcache_controller.
// Backing memory returns word w of block A as 32'h1000_0000 + A + 4*w unless
// the block has been written back, in which case the written data is returned.
module tb_dcache_controller;

  logic         clk;
  logic         rst;
  logic         cpu_req;
  logic         cpu_write;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_controller u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_write_i  (cpu_write),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_rdata),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
`endif
    .mem_ack_i    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent access.
  int           stalls;
  int           wb_cnt;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic [31:0]  rd_addr;
  logic [31:0]  rdata;

  logic [255:0] wb_store [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] blk(input logic [31:0] a);
    logic [255:0] b;
    if (wb_store.exists(a)) return wb_store[a];
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = 32'h1000_0000 + a + 32'(w * 4);
    return b;
  endfunction

  // Called at posedge+1. Presents the access, answers memory requests with
  // mem_ack after ack_dly request cycles, and returns once the stall clears
  // and the completing edge has passed.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_dly);
    int req_cyc;
    bit done;
    stalls  = 0;
    wb_cnt  = 0;
    wb_addr = 32'h0;
    wb_data = 256'h0;
    rd_addr = 32'h0;
    rdata   = 32'h0;
    req_cyc = 0;
    done    = 1'b0;
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (!cpu_stall_o) begin
        rdata = cpu_data_o;
        done  = 1'b1;
      end else begin
        stalls++;
        if (mem_enable_o) begin
          if (req_cyc == ack_dly) begin
            mem_ack = 1'b1;
            req_cyc = 0;
            if (mem_write_o) begin
              wb_cnt++;
              wb_addr = mem_addr_o;
              wb_data = mem_data_o;
              wb_store[mem_addr_o] = mem_data_o;
            end else begin
              rd_addr   = mem_addr_o;
              mem_rdata = blk(mem_addr_o);
            end
          end else begin
            req_cyc++;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    check_eq("access_done", 32'(done), 32'd1);
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_rdata = 256'h0;
    mem_ack   = 1'b0;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(cpu_stall_o), 32'd0);
    check_eq("rst_mem_en", 32'(mem_enable_o), 32'd0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_cpu_data", cpu_data_o, 32'h0);
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    #1;
    check_eq("rst_stall_req", 32'(cpu_stall_o), 32'd1);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Cold clean miss, ack after 2 request cycles.
    access(1'b0, 32'h40, 32'h0, 2);
    check_eq("m1_rd_addr", rd_addr, 32'h40);
    check_eq("m1_wb_cnt", 32'(wb_cnt), 32'd0);
    check_eq("m1_stalls", 32'(stalls), 32'd5);
    check_eq("m1_data", rdata, 32'h1000_0040);

    // Store hit then load hit of the same word.
    access(1'b1, 32'h44, 32'hDEAD_BEEF, 0);
    check_eq("st_hit_stalls", 32'(stalls), 32'd0);
    access(1'b0, 32'h44, 32'h0, 0);
    check_eq("ld_hit_stalls", 32'(stalls), 32'd0);
    check_eq("ld_hit_data", rdata, 32'hDEAD_BEEF);

    // Conflict on dirty index 2: write-back of 0x40 then fetch of 0x240.
    access(1'b0, 32'h244, 32'h0, 1);
    check_eq("dm_wb_cnt", 32'(wb_cnt), 32'd1);
    check_eq("dm_wb_addr", wb_addr, 32'h40);
    check_eq("dm_wb_word1", wb_data[63:32], 32'hDEAD_BEEF);
    check_eq("dm_wb_word0", wb_data[31:0], 32'h1000_0040);
    check_eq("dm_rd_addr", rd_addr, 32'h240);
    check_eq("dm_stalls", 32'(stalls), 32'd6);
    check_eq("dm_data", rdata, 32'h1000_0244);

    // Ack in the first request cycle: clean miss stalls exactly 3.
    access(1'b0, 32'h80, 32'h0, 0);
    check_eq("fast_clean_stalls", 32'(stalls), 32'd3);
    check_eq("fast_clean_data", rdata, 32'h1000_0080);

    // Victim 0x240 is clean: no write-back; refetched 0x40 keeps the stored word.
    access(1'b0, 32'h40, 32'h0, 0);
    check_eq("refetch_wb_cnt", 32'(wb_cnt), 32'd0);
    check_eq("refetch_stalls", 32'(stalls), 32'd3);
    check_eq("refetch_data", rdata, 32'h1000_0040);
    access(1'b0, 32'h44, 32'h0, 0);
    check_eq("refetch_w1", rdata, 32'hDEAD_BEEF);

    // Dirty miss with first-cycle acks stalls exactly 4.
    access(1'b1, 32'h84, 32'hCAFE_F00D, 0);
    access(1'b0, 32'h280, 32'h0, 0);
    check_eq("fast_dirty_stalls", 32'(stalls), 32'd4);
    check_eq("fast_dirty_wb_addr", wb_addr, 32'h80);
    check_eq("fast_dirty_wb_w1", wb_data[63:32], 32'hCAFE_F00D);
    check_eq("fast_dirty_data", rdata, 32'h1000_0280);

    // Reset in the middle of READMISS.
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'hA0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rm_mem_en", 32'(mem_enable_o), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rrm_mem_en", 32'(mem_enable_o), 32'd0);
    check_eq("rrm_mem_addr", mem_addr_o, 32'h0);
    check_eq("rrm_cpu_data", cpu_data_o, 32'h0);
    check_eq("rrm_stall_req", 32'(cpu_stall_o), 32'd1);
    cpu_req = 1'b0;
    #1;
    check_eq("rrm_stall_idle", 32'(cpu_stall_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    access(1'b0, 32'hA0, 32'h0, 0);
    check_eq("post_rst_stalls", 32'(stalls), 32'd3);
    check_eq("post_rst_data", rdata, 32'h1000_00A0);

    // miss (above), then three hits.
    access(1'b0, 32'hA0, 32'h0, 0);
    access(1'b0, 32'hA4, 32'h0, 0);
    check_eq("hit_a4_data", rdata, 32'h1000_00A4);
    access(1'b1, 32'hA8, 32'h1234_5678, 0);
    check_eq("hit_a8_stalls", 32'(stalls), 32'd0);
`ifdef DCACHE_STATS_EN
    check_eq("hit_cnt", hit_cnt_o, 32'd3);
    check_eq("miss_cnt", miss_cnt_o, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameters: none; geometry fixed at 16 lines x 32 bytes, direct-mapped, write-back, write-allocate.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req_i  input  1  MEM-stage access valid (MemRead or MemWrite).
REQ-005 cpu_write_i  input  1  1 = store, 0 = load; sampled only with cpu_req_i.
REQ-006 cpu_addr_i  input  32  byte address; tag [31:9], index [8:5], word [4:2], [1:0] ignored.
REQ-007 cpu_data_i  input  32  store data.
REQ-008 cpu_data_o  output  32  load data.
REQ-009 cpu_stall_o  output  1  freeze pipeline; CPU holds all cpu_* inputs stable while high.
REQ-010 mem_enable_o  output  1  memory request, held until mem_ack_i.
REQ-011 mem_write_o  output  1  1 = block write-back, 0 = block fetch.
REQ-012 mem_addr_o  output  32  block address, [4:0] always 0.
REQ-013 mem_data_o  output  256  write-back block.
REQ-014 mem_data_i  input  256  fetched block, valid in the mem_ack_i cycle.
REQ-015 mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-016 Hit = cpu_req_i & valid[index] & (tag[index] == cpu_addr_i[31:9]); evaluated combinationally.
REQ-017 Read hit: cpu_data_o = word [4:2] of line, same cycle, cpu_stall_o = 0; zero-latency.
REQ-018 Write hit: selected word replaced, dirty[index] set on the clock edge; cpu_stall_o = 0.
REQ-019 cpu_data_o = 0 when no read hit in IDLE.
REQ-020 cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit), combinational, asserted in the miss-detect cycle.
REQ-021 States: IDLE, WRITEBACK, READMISS, REFILLED.
REQ-022 IDLE, miss, valid & dirty victim -> WRITEBACK; miss, clean or invalid victim -> READMISS; otherwise stay.
REQ-023 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; on mem_ack_i -> READMISS.
REQ-024 READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu_addr_i[31:5], 5'b0}; on mem_ack_i capture mem_data_i, set tag, valid=1, dirty=0 -> REFILLED.
REQ-025 REFILLED: no memory request, stall held; -> IDLE, where the access completes as a hit (store sets dirty then).
REQ-026 mem_enable_o, mem_write_o, mem_addr_o, mem_data_o are 0 in IDLE and REFILLED.
REQ-027 mem_ack_i outside WRITEBACK/READMISS is ignored.
REQ-028 mem_ack_i in the first cycle of a request state is accepted; minimum miss penalty: clean 3 stall cycles, dirty 4.
REQ-029 cpu_req_i dropping while in a miss state does not abort the transaction.

Reset
REQ-030 On rst_i low: state IDLE, all valid and dirty bits 0, every output 0 except cpu_stall_o, which follows REQ-020 (0 unless cpu_req_i is high), immediately and asynchronously.
REQ-031 Reset during WRITEBACK/READMISS abandons the transfer; no line, tag or bit updated; tag/data arrays need no reset.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], counting IDLE-cycle accesses as hits or misses. The hit that completes a miss from REFILLED is not counted. Counters are cleared by reset and wrap at 2^32.
REQ-033 Macro undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-034 After reset, load 0x0000_0040 with ack after 2 cycles -> WRITEBACK skipped, mem_addr_o=0x40 read, stall released after REFILLED, cpu_data_o = word 0 of block.
REQ-035 Store 0xDEADBEEF to 0x44 (hit), load 0x44 -> stall 0, cpu_data_o=0xDEADBEEF same cycle.
REQ-036 Load 0x244 (same index 2, different tag) -> write-back of the 0x40 block with word 1 = 0xDEADBEEF, then fetch 0x240.
REQ-037 mem_ack_i asserted in the same cycle mem_enable_o rises -> accepted; clean miss stalls exactly 3 cycles.
REQ-038 rst_i low mid-READMISS -> outputs 0 at once; a following load to the same address misses again.
REQ-039 DCACHE_STATS_EN: sequence hit,miss,hit,hit -> hit_cnt_o=3, miss_cnt_o=1.
